// File: rtl/usb_buf_pkg.sv
// rtl/usb_buf_pkg.sv - shared sizes and FSM state type for the IN-buffer arbiter
package usb_buf_pkg;
  localparam int NUM_REQ = 2;
  localparam int MAX_PKT = 512;
  localparam int ADDR_W  = 9;
  localparam int LEN_W   = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_DROP,
    ST_COMMIT,
    ST_WAIT_ACK
  } state_e;
endpackage

// File: rtl/buf_in_rr_arb.sv
// rtl/buf_in_rr_arb.sv - round-robin one-hot selector; pointer moves past the granted requester on advance
module buf_in_rr_arb
  import usb_buf_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] request,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0] prio_q, prio_d;
  logic [PW-1:0] idx;
  logic          found;

  // Scan starting at the favoured requester; index wraps because NUM_REQ is a power of two
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = prio_q + PW'(k);
      if (!found && request[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (advance) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) prio_d = PW'(i + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) prio_q <= '0;
    else       prio_q <= prio_d;
  end
endmodule

// File: rtl/buf_in_arb.sv
// rtl/buf_in_arb.sv - arbitrates requester byte streams into the 512-byte IN buffer (option: BUF_IN_ARB_ZLP_EN)
module buf_in_arb
  import usb_buf_pkg::*;
(
  input  logic                 phy_ulpi_clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
`ifdef BUF_IN_ARB_ZLP_EN
  input  logic [NUM_REQ-1:0]   req_zlp,
`endif
  input  logic                 buf_in_ready,
  output logic [ADDR_W-1:0]    buf_in_addr,
  output logic [7:0]           buf_in_data,
  output logic                 buf_in_wren,
  output logic                 buf_in_commit,
  output logic [LEN_W-1:0]     buf_in_commit_len,
  input  logic                 buf_in_commit_ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 err_overflow
);
  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [LEN_W-1:0]    count_q, count_d;
  logic                wren_q, wren_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          data_q, data_d;
  logic                commit_q, commit_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                ovf_q, ovf_d;

  logic [NUM_REQ-1:0]  zlp_req;
  logic [NUM_REQ-1:0]  arb_req;
  logic [NUM_REQ-1:0]  rr_grant;
  logic                rr_advance;
  logic                sel_valid, sel_last;
  logic [7:0]          sel_data;
  logic                ack_ok;

`ifdef BUF_IN_ARB_ZLP_EN
  assign zlp_req = req_zlp;
`else
  assign zlp_req = '0;
`endif

  // Outside IDLE the arbiter is fed the owner so that advance rotates past it
  assign arb_req    = (state_q == ST_IDLE) ? (buf_in_ready ? (req_valid | zlp_req) : '0) : grant_q;
  assign ack_ok     = buf_in_commit_ack && (state_q == ST_COMMIT || state_q == ST_WAIT_ACK);
  assign rr_advance = ack_ok;

  buf_in_rr_arb u_rr (
    .clk     (phy_ulpi_clk),
    .reset   (reset),
    .request (arb_req),
    .advance (rr_advance),
    .grant   (rr_grant)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        sel_valid = sel_valid | req_valid[i];
        sel_last  = sel_last  | req_last[i];
        sel_data  = sel_data  | req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    count_d  = count_q;
    wren_d   = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    commit_d = 1'b0;
    len_d    = len_q;
    ovf_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|rr_grant) begin
          grant_d = rr_grant;
          count_d = '0;
          state_d = (|(rr_grant & zlp_req)) ? ST_COMMIT : ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (sel_valid) begin
          wren_d  = 1'b1;
          addr_d  = count_q[ADDR_W-1:0];
          data_d  = sel_data;
          count_d = count_q + LEN_W'(1);
          if (sel_last) begin
            state_d = ST_COMMIT;
          end else if (count_q == LEN_W'(MAX_PKT - 1)) begin
            ovf_d   = 1'b1;
            state_d = ST_DROP;
          end
        end
      end
      ST_DROP: begin
        if (sel_valid && sel_last) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        commit_d = 1'b1;
        len_d    = count_q;
        if (ack_ok) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end else begin
          state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (ack_ok) begin
          state_d = ST_IDLE;
          grant_d = '0;
          len_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge phy_ulpi_clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      count_q  <= '0;
      wren_q   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      commit_q <= 1'b0;
      len_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      count_q  <= count_d;
      wren_q   <= wren_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      commit_q <= commit_d;
      len_q    <= len_d;
      ovf_q    <= ovf_d;
    end
  end

  assign req_ready         = (state_q == ST_WRITE || state_q == ST_DROP) ? grant_q : '0;
  assign grant             = grant_q;
  assign busy              = (state_q != ST_IDLE);
  assign buf_in_wren       = wren_q;
  assign buf_in_addr       = addr_q;
  assign buf_in_data       = data_q;
  assign buf_in_commit     = commit_q;
  assign buf_in_commit_len = len_q;
  assign err_overflow      = ovf_q;
endmodule

// File: tb/tb_buf_in_arb.sv
// tb/tb_buf_in_arb.sv - self-checking bench for buf_in_arb (ZLP cases under BUF_IN_ARB_ZLP_EN)
module tb_buf_in_arb;
  import usb_buf_pkg::*;

  logic        phy_ulpi_clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
`ifdef BUF_IN_ARB_ZLP_EN
  logic [1:0]  req_zlp;
`endif
  logic        buf_in_ready;
  logic [8:0]  buf_in_addr;
  logic [7:0]  buf_in_data;
  logic        buf_in_wren;
  logic        buf_in_commit;
  logic [9:0]  buf_in_commit_len;
  logic        buf_in_commit_ack;
  logic [1:0]  grant;
  logic        busy;
  logic        err_overflow;

  buf_in_arb dut (
    .phy_ulpi_clk      (phy_ulpi_clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_data          (req_data),
    .req_last          (req_last),
    .req_ready         (req_ready),
`ifdef BUF_IN_ARB_ZLP_EN
    .req_zlp           (req_zlp),
`endif
    .buf_in_ready      (buf_in_ready),
    .buf_in_addr       (buf_in_addr),
    .buf_in_data       (buf_in_data),
    .buf_in_wren       (buf_in_wren),
    .buf_in_commit     (buf_in_commit),
    .buf_in_commit_len (buf_in_commit_len),
    .buf_in_commit_ack (buf_in_commit_ack),
    .grant             (grant),
    .busy              (busy),
    .err_overflow      (err_overflow)
  );

  always #5 phy_ulpi_clk = ~phy_ulpi_clk;

  typedef struct packed {
    logic [1:0] g;
    logic [9:0] len;
  } commit_t;

  typedef struct {
    int         r;
    int         n;
    logic [7:0] base;
    logic [1:0] eg;
    int         elen;
    int         ewr;
    int         eovf;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [8:0] txq [2][$];
  logic [7:0] exp_bytes[$];
  commit_t    expc[$];
  int pkt_wrens = 0, total_wrens = 0, ovf_cnt = 0, commit_cnt = 0;
  logic [1:0] acc_prev = 2'b00;
  logic [1:0] zlp_pulse = 2'b00;
  int ack_cnt = -1, ack_delay_max = 0;
  bit stall_en = 1'b0, rnd_ready = 1'b0, wait_ack = 1'b0;
  logic [9:0] held_len = '0;
  int last_acc_cyc = 0, last_wren_cyc = 0, last_commit_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_commit(input logic [1:0] g, input int len);
    commit_t c;
    c.g   = g;
    c.len = 10'(len);
    expc.push_back(c);
  endtask

  // One clock: sample outputs at negedge, score them, then drive the next inputs
  task automatic step();
    commit_t e;
    @(negedge phy_ulpi_clk);
    cyc++;
    for (int r = 0; r < 2; r++) begin
      if (acc_prev[r] && txq[r].size() > 0) begin
        txq[r].delete(0);
        last_acc_cyc = cyc - 1;
      end
    end
    if (wait_ack) check("len_hold", buf_in_commit_len, held_len);
    if (buf_in_wren) begin
      last_wren_cyc = cyc;
      if (exp_bytes.size() == 0) check("unexpected_wren", 1, 0);
      else begin
        check("wren_addr", buf_in_addr, pkt_wrens);
        check("wren_data", buf_in_data, exp_bytes.pop_front());
      end
      pkt_wrens++;
      total_wrens++;
    end
    if (err_overflow) ovf_cnt++;
    if (buf_in_commit) begin
      commit_cnt++;
      last_commit_cyc = cyc;
      pkt_wrens = 0;
      if (expc.size() == 0) check("unexpected_commit", 1, 0);
      else begin
        e = expc.pop_front();
        check("commit_grant", grant, e.g);
        check("commit_len", buf_in_commit_len, e.len);
      end
      wait_ack = 1'b1;
      held_len = buf_in_commit_len;
      ack_cnt  = (ack_delay_max > 0) ? int'($urandom_range(0, ack_delay_max)) : 0;
    end
    if (ack_cnt == 0) begin
      buf_in_commit_ack = 1'b1;
      ack_cnt = -1;
      wait_ack = 1'b0;
    end else begin
      buf_in_commit_ack = 1'b0;
      if (ack_cnt > 0) ack_cnt--;
    end
    if (rnd_ready) buf_in_ready = ($urandom_range(0, 9) < 7);
    for (int r = 0; r < 2; r++) begin
      if (txq[r].size() > 0 && !(stall_en && grant[r] && $urandom_range(0, 3) == 0)) begin
        req_valid[r]       = 1'b1;
        req_data[8*r +: 8] = txq[r][0][7:0];
        req_last[r]        = txq[r][0][8];
      end else begin
        req_valid[r] = 1'b0;
        req_last[r]  = 1'b0;
      end
    end
    acc_prev = req_valid & req_ready;
`ifdef BUF_IN_ARB_ZLP_EN
    req_zlp   = zlp_pulse;
`endif
    zlp_pulse = 2'b00;
  endtask

  task automatic clear_state();
    txq[0].delete();
    txq[1].delete();
    exp_bytes.delete();
    expc.delete();
    acc_prev = 2'b00;
    wait_ack = 1'b0;
    ack_cnt = -1;
    pkt_wrens = 0;
    buf_in_commit_ack = 1'b0;
    req_valid = 2'b00;
    req_last = 2'b00;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    clear_state();
    for (int i = 0; i < n; i++) begin
      step();
      check("reset_outs", {req_ready, buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit,
                           buf_in_commit_len, grant, busy, err_overflow}, 64'd0);
    end
    reset = 1'b0;
  endtask

  task automatic wait_commits(input int target, input int budget);
    int n = 0;
    while ((commit_cnt < target || busy) && n < budget) begin
      step();
      n++;
    end
    check("done_in_time", n < budget, 1);
  endtask

  task automatic send(input int r, input int n, input logic [7:0] base);
    for (int j = 0; j < n; j++) begin
      txq[r].push_back({j == n - 1, 8'(base + 8'(j))});
      if (j < MAX_PKT) exp_bytes.push_back(8'(base + 8'(j)));
    end
  endtask

  task automatic run_table();
    vec_t tbl[5];
    int wr0, ov0;
    tbl[0] = '{r:0, n:4,   base:8'h11, eg:2'b01, elen:4,   ewr:4,   eovf:0};
    tbl[1] = '{r:1, n:1,   base:8'hA0, eg:2'b10, elen:1,   ewr:1,   eovf:0};
    tbl[2] = '{r:0, n:512, base:8'h00, eg:2'b01, elen:512, ewr:512, eovf:0};
    tbl[3] = '{r:1, n:513, base:8'h40, eg:2'b10, elen:512, ewr:512, eovf:1};
    tbl[4] = '{r:0, n:600, base:8'h80, eg:2'b01, elen:512, ewr:512, eovf:1};
    for (int i = 0; i < 5; i++) begin
      wr0 = total_wrens;
      ov0 = ovf_cnt;
      send(tbl[i].r, tbl[i].n, tbl[i].base);
      push_commit(tbl[i].eg, tbl[i].elen);
      wait_commits(commit_cnt + 1, 2000);
      check("tbl_wrens", total_wrens - wr0, tbl[i].ewr);
      check("tbl_ovf", ovf_cnt - ov0, tbl[i].eovf);
      if (i < 2) begin
        check("acc_to_wren", last_wren_cyc - last_acc_cyc, 1);
        check("wren_to_commit", last_commit_cyc - last_wren_cyc, 1);
      end
    end
  endtask

  // Transaction-level model: whole packets served round-robin, truncated to MAX_PKT
  task automatic run_random();
    int plen [2][$];
    logic [7:0] mq [2][$];
    int n, p, r, exp_ovf, ov0;
    logic [7:0] b;
    ov0 = ovf_cnt;
    for (int q = 0; q < 2; q++) begin
      for (int k = 0; k < 3; k++) begin
        n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(508, 516)) : int'($urandom_range(1, 16));
        plen[q].push_back(n);
        for (int j = 0; j < n; j++) begin
          b = 8'($urandom);
          txq[q].push_back({j == n - 1, b});
          mq[q].push_back(b);
        end
      end
    end
    p = 0;
    exp_ovf = 0;
    while (plen[0].size() + plen[1].size() > 0) begin
      r = (plen[p].size() > 0) ? p : 1 - p;
      n = plen[r].pop_front();
      for (int j = 0; j < n; j++) begin
        b = mq[r].pop_front();
        if (j < MAX_PKT) exp_bytes.push_back(b);
      end
      push_commit(2'(1 << r), (n > MAX_PKT) ? MAX_PKT : n);
      if (n > MAX_PKT) exp_ovf++;
      p = 1 - r;
    end
    stall_en = 1'b1;
    rnd_ready = 1'b1;
    ack_delay_max = 3;
    wait_commits(commit_cnt + 6, 20000);
    stall_en = 1'b0;
    rnd_ready = 1'b0;
    ack_delay_max = 0;
    buf_in_ready = 1'b1;
    check("rnd_ovf", ovf_cnt - ov0, exp_ovf);
    check("rnd_leftover", expc.size() + exp_bytes.size(), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0, wr0, n;
    reset = 1'b1;
    req_valid = 2'b00;
    req_data = '0;
    req_last = 2'b00;
`ifdef BUF_IN_ARB_ZLP_EN
    req_zlp = 2'b00;
`endif
    buf_in_ready = 1'b1;
    buf_in_commit_ack = 1'b0;

    do_reset(3);
    run_table();

    // Simultaneous requesters from a fresh pointer: 0, 1, 0, 1
    do_reset(1);
    send(0, 2, 8'h20);
    send(1, 3, 8'h30);
    send(0, 2, 8'h24);
    send(1, 3, 8'h34);
    exp_bytes.delete();
    send(-1, 0, 8'h00);
    for (int j = 0; j < 2; j++) exp_bytes.push_back(8'h20 + 8'(j));
    for (int j = 0; j < 3; j++) exp_bytes.push_back(8'h30 + 8'(j));
    for (int j = 0; j < 2; j++) exp_bytes.push_back(8'h24 + 8'(j));
    for (int j = 0; j < 3; j++) exp_bytes.push_back(8'h34 + 8'(j));
    push_commit(2'b01, 2);
    push_commit(2'b10, 3);
    push_commit(2'b01, 2);
    push_commit(2'b10, 3);
    wait_commits(commit_cnt + 4, 200);

    // Buffer not ready: no grant until it rises
    buf_in_ready = 1'b0;
    send(1, 2, 8'h50);
    push_commit(2'b10, 2);
    for (int i = 0; i < 4; i++) begin
      step();
      check("nordy_grant", grant, 2'b00);
      check("nordy_busy", busy, 1'b0);
    end
    buf_in_ready = 1'b1;
    step();
    check("rdy_grant", grant, 2'b10);
    wait_commits(commit_cnt + 1, 100);

    // Reset ten bytes into a packet
    c0 = commit_cnt;
    wr0 = total_wrens;
    send(0, 20, 8'h60);
    n = 0;
    while (total_wrens - wr0 < 10 && n < 100) begin
      step();
      n++;
    end
    check("pre_reset_wrens", total_wrens - wr0, 10);
    reset = 1'b1;
    clear_state();
    step();
    check("midrst_outs", {req_ready, buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit,
                          buf_in_commit_len, grant, busy, err_overflow}, 64'd0);
    reset = 1'b0;
    step();
    step();
    check("midrst_no_commit", commit_cnt, c0);
    send(1, 3, 8'h70);
    push_commit(2'b10, 3);
    wait_commits(commit_cnt + 1, 100);

`ifdef BUF_IN_ARB_ZLP_EN
    wr0 = total_wrens;
    zlp_pulse = 2'b10;
    push_commit(2'b10, 0);
    wait_commits(commit_cnt + 1, 50);
    check("zlp_wrens", total_wrens - wr0, 0);
    check("zlp_idle", busy, 1'b0);
`endif

    run_random();
    run_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/buf_in_arb.md
BUF_IN_ARB -- requirements
Module: buf_in_arb

Interface
REQ-001 SHALL have the following ports:
- phy_ulpi_clk  in  1  sole clock, all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester byte valid.
- req_data  in  16  per-requester byte; requester i on bits [8i+7:8i].
- req_last  in  2  marks the final byte of the packet.
- req_ready  out  2  byte accepted on valid&ready.
- req_zlp  in  2  zero-length packet request (BUF_IN_ARB_ZLP_EN only).
- buf_in_ready  in  1  IN buffer free.
- buf_in_addr  out  9  write address.
- buf_in_data  out  8  write data.
- buf_in_wren  out  1  write strobe.
- buf_in_commit  out  1  one-cycle commit pulse.
- buf_in_commit_len  out  10  committed byte count, 0..512.
- buf_in_commit_ack  in  1  commit accepted.
- grant  out  2  one-hot current owner; 0 when idle.
- busy  out  1  high in any state other than IDLE.
- err_overflow  out  1  one-cycle pulse when a packet exceeds 512 bytes.

Function
REQ-002 SHALL implement the states IDLE, WRITE, DROP, COMMIT and WAIT_ACK.
REQ-003 In IDLE with buf_in_ready=1 and any req_valid (or req_zlp) high, SHALL grant one requester round-robin and go to WRITE next cycle.
REQ-004 The round-robin pointer SHALL favour the requester after the last granted one, and SHALL advance only on commit ack; requester 0 has priority after reset.
REQ-005 In WRITE, req_ready SHALL equal grant; the other requester's req_ready SHALL be 0.
REQ-006 Each valid&ready byte SHALL drive buf_in_wren=1 on the next cycle, with buf_in_addr=byte index (from 0) and buf_in_data=the byte; this is 1-cycle registered latency.
REQ-007 If req_valid drops mid-packet, the block SHALL stall in WRITE; there is no timeout.
REQ-008 A byte with req_last=1 SHALL end WRITE; COMMIT SHALL follow the cycle after its write strobe.
REQ-009 In COMMIT, the block SHALL pulse buf_in_commit for one cycle with buf_in_commit_len=byte count, then enter WAIT_ACK.
REQ-010 buf_in_commit_len SHALL hold its value until ack.
REQ-011 buf_in_commit_ack SHALL be honoured in COMMIT or WAIT_ACK: the block returns to IDLE next cycle, grant goes to 0 and the pointer rotates.
REQ-012 If the 512th byte is not last, the block SHALL pulse err_overflow once and enter DROP.
REQ-013 In DROP, req_ready SHALL stay high and bytes SHALL be discarded with no wren until req_last; the block SHALL then commit length 512.
REQ-014 buf_in_ready SHALL be sampled only in IDLE; its deassertion mid-packet SHALL be ignored.
REQ-015 If both requesters become valid in the same cycle, exactly one grant SHALL be issued per REQ-004.

Reset
REQ-016 While reset=1, the block SHALL force state IDLE and pointer 0.
REQ-017 While reset=1, all outputs SHALL be 0.
REQ-018 Any partial packet SHALL be abandoned on reset without a commit.
REQ-019 Reset asserted mid-packet SHALL take effect on the next edge.

Configuration
REQ-020 With BUF_IN_ARB_ZLP_EN defined:
- req_zlp SHALL be an arbitration request like req_valid.
- A granted requester with req_zlp=1 in IDLE SHALL go directly to COMMIT with len 0 and no wren.
- req_zlp has priority over req_valid from the same requester.
REQ-021 Without BUF_IN_ARB_ZLP_EN, the req_zlp port SHALL be absent and zero-length commits SHALL never occur.

Structure
REQ-022 The shared package usb_buf_pkg SHALL hold:
- the state enum;
- NUM_REQ=2;
- MAX_PKT=512;
- ADDR_W=9 and LEN_W=10.
REQ-023 Round-robin selection SHALL be the sub-module buf_in_rr_arb: inputs request[1:0] and advance; output one-hot grant.

Verification
REQ-024 After reset, req0 sends 4 bytes 0x11..0x14 -> wren at addr 0..3 with that data, commit_len=4, grant=01 until ack.
REQ-025 With both requesters valid at once -> req0 is served first; after ack, req1 is served; after the next ack, req0 wins again.
REQ-026 req0 sends 600 bytes -> 512 wrens, one err_overflow pulse, 88 bytes dropped, commit_len=512.
REQ-027 Reset is asserted after 10 bytes of a packet -> all outputs 0 next cycle, no commit; the next packet starts at addr 0.
REQ-028 buf_in_ready=0 with req1 valid -> no grant; after buf_in_ready rises, grant=10 within 1 cycle.
REQ-029 With ZLP_EN, req1 pulses req_zlp -> commit with len 0, no wren; ack returns the block to IDLE.
